vip_stream_decode: RTL and testbench

Avalon-ST Video input decoder for the video pipeline. It sits in front of the per-pixel processing cores (for example gray balance).
- Parses control packets for any plane count and commits width, height and interlace atomically.
- Forwards video packets with zero latency and forwards or drops user packets.
- Tracks the pixel position inside each frame and flags frames that are shorter or longer than the committed geometry.

---
 rtl/vip_stream_decode.sv | 200 ++++++++++++++++++++
 tb/tb_vip_stream_decode.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_stream_decode.sv
// Avalon-ST Video input decoder: parses control packets, forwards video/user
// packets with zero latency and checks incoming frames against the committed geometry.
module vip_stream_decode #(
    parameter int unsigned COLOR_BITS   = 14,
    parameter int unsigned COLOR_PLANES = 1,
    parameter int unsigned DATA_WIDTH   = COLOR_BITS * COLOR_PLANES,
    parameter bit          PASS_USER    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic                  din_valid,
    input  logic                  din_startofpacket,
    input  logic                  din_endofpacket,
    output logic                  din_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket,
    input  logic                  dout_ready,
    output logic [15:0]           im_width,
    output logic [15:0]           im_height,
    output logic [3:0]            im_interlaced,
    output logic                  ctrl_update,
    output logic [15:0]           pix_x,
    output logic [15:0]           pix_y,
    output logic                  err_short,
    output logic                  err_long
);

    localparam int unsigned HDR_NIBS  = 9;
    localparam int unsigned HDR_BEATS = (HDR_NIBS + COLOR_PLANES - 1) / COLOR_PLANES;
    localparam logic [3:0]  HDR_LAST  = 4'(HDR_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CTRL,
        VIDEO,
        USER_FWD,
        USER_DROP
    } state_t;

    state_t                  state;
    logic [3:0]              sop_type;
    logic                    is_video;
    logic                    is_ctrl;
    logic                    fwd;
    logic                    xfer;
    logic [3:0]              hdr_cnt;
    logic [4*HDR_NIBS-1:0]   hdr_q;
    logic [4*HDR_NIBS-1:0]   hdr_next;
    int unsigned             nib_idx;
    logic [15:0]             geo_w;
    logic [15:0]             geo_h;
    logic                    chk;
    logic                    reached;
    logic                    long_seen;
    logic                    at_end;

    assign sop_type = din_data[3:0];
    assign is_video = (sop_type == 4'h0);
    assign is_ctrl  = (sop_type == 4'hF);

    // A SOP beat is always decoded by its type, whatever packet it interrupts.
    always_comb begin
        if (din_startofpacket) begin
            fwd = is_video || (!is_ctrl && PASS_USER);
        end else begin
            fwd = (state == VIDEO) || (state == USER_FWD);
        end
    end

    assign din_ready          = fwd ? dout_ready : 1'b1;
    assign dout_valid         = fwd & din_valid;
    assign dout_data          = din_data;
    assign dout_startofpacket = fwd & din_startofpacket;
    assign dout_endofpacket   = fwd & din_endofpacket;
    assign xfer               = din_valid & din_ready;

    assign at_end = (pix_x == geo_w - 16'd1) && (pix_y == geo_h - 16'd1);

    // Shadow header including the current beat, so the EOP beat's nibbles are committed too.
    always_comb begin
        hdr_next = hdr_q;
        nib_idx  = 0;
        for (int unsigned p = 0; p < COLOR_PLANES; p++) begin
            nib_idx = 32'(hdr_cnt) * COLOR_PLANES + p;
            if (nib_idx < HDR_NIBS) begin
                hdr_next[nib_idx*4 +: 4] = din_data[p*COLOR_BITS +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            hdr_cnt       <= '0;
            hdr_q         <= '0;
            im_width      <= '0;
            im_height     <= '0;
            im_interlaced <= '0;
            ctrl_update   <= 1'b0;
            pix_x         <= '0;
            pix_y         <= '0;
            geo_w         <= '0;
            geo_h         <= '0;
            chk           <= 1'b0;
            reached       <= 1'b0;
            long_seen     <= 1'b0;
            err_short     <= 1'b0;
            err_long      <= 1'b0;
        end else begin
            ctrl_update <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            if (xfer) begin
                if (din_startofpacket) begin
                    if (state == VIDEO && chk && !reached) begin
                        err_short <= 1'b1;
                    end
                    hdr_cnt <= '0;
                    if (is_video) begin
                        pix_x     <= '0;
                        pix_y     <= '0;
                        geo_w     <= im_width;
                        geo_h     <= im_height;
                        chk       <= (im_width != 16'd0) && (im_height != 16'd0);
                        reached   <= 1'b0;
                        long_seen <= 1'b0;
                    end
                    if (din_endofpacket) begin
                        state <= IDLE;
                        // A video packet with no pixels at all is short.
                        if (is_video && im_width != 16'd0 && im_height != 16'd0) begin
                            err_short <= 1'b1;
                        end
                    end else if (is_video) begin
                        state <= VIDEO;
                    end else if (is_ctrl) begin
                        state <= CTRL;
                    end else if (PASS_USER) begin
                        state <= USER_FWD;
                    end else begin
                        state <= USER_DROP;
                    end
                end else begin
                    case (state)
                        CTRL: begin
                            hdr_q <= hdr_next;
                            if (hdr_cnt != 4'hF) begin
                                hdr_cnt <= hdr_cnt + 4'd1;
                            end
                            if (din_endofpacket) begin
                                state <= IDLE;
                                if (hdr_cnt >= HDR_LAST) begin
                                    im_width      <= {hdr_next[3:0], hdr_next[7:4],
                                                      hdr_next[11:8], hdr_next[15:12]};
                                    im_height     <= {hdr_next[19:16], hdr_next[23:20],
                                                      hdr_next[27:24], hdr_next[31:28]};
                                    im_interlaced <= hdr_next[35:32];
                                    ctrl_update   <= 1'b1;
                                end
                            end
                        end
                        VIDEO: begin
                            if (pix_x == geo_w - 16'd1) begin
                                pix_x <= '0;
                                if (pix_y != 16'hFFFF) begin
                                    pix_y <= pix_y + 16'd1;
                                end
                            end else begin
                                pix_x <= pix_x + 16'd1;
                            end
                            if (chk && !long_seen && pix_y >= geo_h) begin
                                err_long  <= 1'b1;
                                long_seen <= 1'b1;
                            end
                            if (at_end) begin
                                reached <= 1'b1;
                            end
                            if (din_endofpacket) begin
                                state <= IDLE;
                                if (chk && !(reached || at_end)) begin
                                    err_short <= 1'b1;
                                end
                            end
                        end
                        USER_FWD, USER_DROP: begin
                            if (din_endofpacket) begin
                                state <= IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_vip_stream_decode.sv
// Scoreboard bench for vip_stream_decode: a 1-plane drop-user instance and a
// 3-plane forward-user instance driven by directed packets.
module tb_vip_stream_decode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [41:0] din_data = '0;
    logic        din_sop = 1'b0;
    logic        din_eop = 1'b0;
    logic        va = 1'b0;
    logic        vb = 1'b0;
    logic        dout_ready = 1'b1;
    logic        bp_en = 1'b0;

    logic        din_ready_a, dout_valid_a, dout_sop_a, dout_eop_a;
    logic [13:0] dout_data_a;
    logic [15:0] im_width_a, im_height_a, pix_x_a, pix_y_a;
    logic [3:0]  im_interlaced_a;
    logic        ctrl_update_a, err_short_a, err_long_a;

    logic        din_ready_b, dout_valid_b, dout_sop_b, dout_eop_b;
    logic [41:0] dout_data_b;
    logic [15:0] im_width_b, im_height_b, pix_x_b, pix_y_b;
    logic [3:0]  im_interlaced_b;
    logic        ctrl_update_b, err_short_b, err_long_b;

    vip_stream_decode #(.COLOR_BITS(14), .COLOR_PLANES(1), .DATA_WIDTH(14), .PASS_USER(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .din_data(din_data[13:0]), .din_valid(va), .din_startofpacket(din_sop),
        .din_endofpacket(din_eop), .din_ready(din_ready_a),
        .dout_data(dout_data_a), .dout_valid(dout_valid_a), .dout_startofpacket(dout_sop_a),
        .dout_endofpacket(dout_eop_a), .dout_ready(dout_ready),
        .im_width(im_width_a), .im_height(im_height_a), .im_interlaced(im_interlaced_a),
        .ctrl_update(ctrl_update_a), .pix_x(pix_x_a), .pix_y(pix_y_a),
        .err_short(err_short_a), .err_long(err_long_a)
    );

    vip_stream_decode #(.COLOR_BITS(14), .COLOR_PLANES(3), .DATA_WIDTH(42), .PASS_USER(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .din_data(din_data), .din_valid(vb), .din_startofpacket(din_sop),
        .din_endofpacket(din_eop), .din_ready(din_ready_b),
        .dout_data(dout_data_b), .dout_valid(dout_valid_b), .dout_startofpacket(dout_sop_b),
        .dout_endofpacket(dout_eop_b), .dout_ready(dout_ready),
        .im_width(im_width_b), .im_height(im_height_b), .im_interlaced(im_interlaced_b),
        .ctrl_update(ctrl_update_b), .pix_x(pix_x_b), .pix_y(pix_y_b),
        .err_short(err_short_b), .err_long(err_long_b)
    );

    int n_checks = 0;
    int n_errs = 0;
    int sh_a = 0;
    int lg_a = 0;
    int ct_a = 0;
    int ct_b = 0;
    int long_at = -1;
    int pix_seen = 0;
    int unsigned cyc;
    logic [15:0] qa[$];
    logic [43:0] qb[$];
    logic [31:0] posq[$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        dout_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Monitor: pulse counters first, then any output transfer is popped and compared.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_short_a) sh_a++;
            if (err_long_a) begin
                lg_a++;
                long_at = pix_seen;
            end
            if (ctrl_update_a) ct_a++;
            if (ctrl_update_b) ct_b++;
            if (dout_valid_a && dout_ready) begin
                if (qa.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL beat_a unexpected actual=%0h required=none", dout_data_a);
                end else begin
                    check("beat_a", 64'({dout_sop_a, dout_eop_a, dout_data_a}), 64'(qa.pop_front()));
                end
                if (!dout_sop_a) begin
                    if (posq.size() == 0) begin
                        n_checks++;
                        n_errs++;
                        $display("FAIL pos_a unexpected actual=%0h required=none", {pix_y_a, pix_x_a});
                    end else begin
                        check("pos_a", 64'({pix_y_a, pix_x_a}), 64'(posq.pop_front()));
                    end
                    pix_seen++;
                end
            end
            if (dout_valid_b && dout_ready) begin
                if (qb.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL beat_b unexpected actual=%0h required=none", dout_data_b);
                end else begin
                    check("beat_b", 64'({dout_sop_b, dout_eop_b, dout_data_b}), 64'(qb.pop_front()));
                end
            end
        end
    end

    task automatic send(input bit to_b, input logic [41:0] d, input bit s, input bit e,
                        input bit fwd, output int unsigned ncyc);
        bit ok;
        if (fwd) begin
            if (to_b) qb.push_back({s, e, d});
            else      qa.push_back({s, e, d[13:0]});
        end
        din_data = d;
        din_sop  = s;
        din_eop  = e;
        if (to_b) vb = 1'b1; else va = 1'b1;
        ncyc = 0;
        ok = 1'b0;
        while (!ok && ncyc < 200) begin
            @(negedge clk);
            ok = to_b ? din_ready_b : din_ready_a;
            @(posedge clk);
            #1;
            ncyc++;
        end
        va = 1'b0;
        vb = 1'b0;
        if (!ok) begin
            n_checks++;
            n_errs++;
            $display("FAIL handshake_timeout actual=%0d required=<200", ncyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // nibs holds the nine header nibbles, nibble 0 in the top digit.
    task automatic ctrl_a(input logic [35:0] nibs);
        send(1'b0, 42'hF, 1'b1, 1'b0, 1'b0, cyc);
        for (int i = 0; i < 9; i++) begin
            send(1'b0, {28'h0, 10'h3A5, nibs[(8-i)*4 +: 4]}, 1'b0, i == 8, 1'b0, cyc);
        end
    endtask

    task automatic ctrl_b(input logic [35:0] nibs, input int beats);
        logic [41:0] d;
        send(1'b1, 42'hF, 1'b1, 1'b0, 1'b0, cyc);
        for (int b = 0; b < beats; b++) begin
            d = '0;
            for (int p = 0; p < 3; p++) begin
                d[p*14 +: 4] = nibs[(8-(b*3+p))*4 +: 4];
            end
            send(1'b1, d, 1'b0, b == beats - 1, 1'b0, cyc);
        end
    endtask

    // Video packet on instance A (geometry 4 wide); positions pushed for each pixel.
    task automatic vid_a(input int npix, input bit with_eop);
        send(1'b0, 42'h0, 1'b1, (npix == 0) && with_eop, 1'b1, cyc);
        for (int i = 0; i < npix; i++) begin
            posq.push_back({16'(i / 4), 16'(i % 4)});
            send(1'b0, 42'(14'h100 + i), 1'b0, (i == npix - 1) && with_eop, 1'b1, cyc);
        end
    endtask

    initial begin
        wait_cyc(3);
        check("rst_im_width_a", 64'(im_width_a), 64'h0);
        check("rst_im_height_b", 64'(im_height_b), 64'h0);
        check("rst_ctrl_update_a", 64'(ctrl_update_a), 64'h0);
        check("rst_pix_a", 64'({pix_y_a, pix_x_a}), 64'h0);
        check("rst_err_a", 64'({err_short_a, err_long_a}), 64'h0);
        rst_n = 1'b1;
        wait_cyc(2);

        ctrl_a(36'h0140_00F0_3);
        wait_cyc(3);
        check("ctrl1_width", 64'(im_width_a), 64'h0140);
        check("ctrl1_height", 64'(im_height_a), 64'h00F0);
        check("ctrl1_interlace", 64'(im_interlaced_a), 64'h3);
        check("ctrl1_update_count", 64'(ct_a), 64'd1);

        ctrl_b(36'h0780_0438_0, 3);
        wait_cyc(3);
        check("ctrl3_width", 64'(im_width_b), 64'h0780);
        check("ctrl3_height", 64'(im_height_b), 64'h0438);
        check("ctrl3_interlace", 64'(im_interlaced_b), 64'h0);
        check("ctrl3_update_count", 64'(ct_b), 64'd1);
        ctrl_b(36'h0123_0456_7, 2);
        wait_cyc(3);
        check("ctrl3_short_width", 64'(im_width_b), 64'h0780);
        check("ctrl3_short_height", 64'(im_height_b), 64'h0438);
        check("ctrl3_short_update_count", 64'(ct_b), 64'd1);

        ctrl_a(36'h0004_0002_0);
        wait_cyc(3);
        check("geo_width", 64'(im_width_a), 64'h4);
        check("geo_height", 64'(im_height_a), 64'h2);
        check("geo_update_count", 64'(ct_a), 64'd2);

        bp_en = 1'b1;
        sh_a = 0; lg_a = 0; pix_seen = 0;
        vid_a(8, 1'b1);
        wait_cyc(3);
        check("exact_short", 64'(sh_a), 64'd0);
        check("exact_long", 64'(lg_a), 64'd0);

        sh_a = 0; lg_a = 0; pix_seen = 0;
        vid_a(6, 1'b1);
        wait_cyc(3);
        check("six_short", 64'(sh_a), 64'd1);
        check("six_long", 64'(lg_a), 64'd0);

        sh_a = 0; lg_a = 0; pix_seen = 0; long_at = -1;
        vid_a(10, 1'b1);
        wait_cyc(3);
        check("ten_long", 64'(lg_a), 64'd1);
        check("ten_long_at", 64'(long_at), 64'd9);
        check("ten_short", 64'(sh_a), 64'd0);

        send(1'b0, 42'h5, 1'b1, 1'b0, 1'b0, cyc);
        check("drop_ready_sop", 64'(cyc), 64'd1);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 42'(14'h2A0 + i), 1'b0, i == 2, 1'b0, cyc);
            check("drop_ready", 64'(cyc), 64'd1);
        end

        send(1'b1, 42'h155_0000_0005, 1'b1, 1'b0, 1'b1, cyc);
        send(1'b1, 42'h3FF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, cyc);
        send(1'b1, 42'h0AB_CDEF_0123, 1'b0, 1'b0, 1'b1, cyc);
        send(1'b1, 42'h200_0000_0001, 1'b0, 1'b1, 1'b1, cyc);

        sh_a = 0; lg_a = 0; pix_seen = 0;
        vid_a(3, 1'b0);
        vid_a(8, 1'b1);
        wait_cyc(3);
        check("abort_short", 64'(sh_a), 64'd1);
        check("abort_long", 64'(lg_a), 64'd0);

        bp_en = 1'b0;
        wait_cyc(1);
        vid_a(2, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_pix", 64'({pix_y_a, pix_x_a}), 64'h0);
        check("midrst_width", 64'(im_width_a), 64'h0);
        check("midrst_outputs", 64'({dout_valid_a, ctrl_update_a, err_short_a, err_long_a}), 64'h0);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(1);
        send(1'b0, 42'h1234, 1'b0, 1'b1, 1'b0, cyc);
        check("midrst_idle_ready", 64'(cyc), 64'd1);

        wait_cyc(5);
        check("drain_qa", 64'(qa.size()), 64'd0);
        check("drain_qb", 64'(qb.size()), 64'd0);
        check("drain_pos", 64'(posq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
